// File: rtl/uart_pkg.sv
// Shared UART constants and types (receiver and transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned OversampleDefault = 16;
  localparam int unsigned DataBitsDefault   = 8;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  // Parity bit a transmitter would append to data (zero-extended to 32 bits).
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/rx_sipo.sv
// Serial-in/parallel-out register; first bit in ends up at bit 0 (LSB-first line order).
module rx_sipo #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] parallel_out
);

  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS:0]   shift_ext;

  assign shift_ext    = {serial_in, shift_q};
  assign parallel_out = shift_q;

  // New bit enters at the MSB, older bits move towards the LSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= shift_ext[DATA_BITS:1];
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 2-flop RxD synchronizer, oversampled bit-timing FSM,
// parity/stop checking and registered one-cycle result strobes.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DataBitsDefault,
  parameter int unsigned OVERSAMPLE = OversampleDefault,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  input  logic                 Rx_EN,
  input  logic                 Rx_sample_enable,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR,
  output logic                 Rx_BUSY
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CntW-1:0] MidTick  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] LastBit  = IdxW'(DATA_BITS - 1);

  logic                 rxd_meta_q, rxd_sync_q;
  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perror_q, perror_d;
  logic                 ferror_q, ferror_d;
  logic                 shift_en;
  logic [DATA_BITS-1:0] sipo_out;

  rx_sipo #(
    .DATA_BITS(DATA_BITS)
  ) u_sipo (
    .clk         (clk),
    .reset       (reset),
    .shift_en    (shift_en),
    .serial_in   (rxd_sync_q),
    .parallel_out(sipo_out)
  );

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Next-state, counters and result strobes; everything advances only on a sample tick.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    perr_d   = perr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perror_d = 1'b0;
    ferror_d = 1'b0;
    shift_en = 1'b0;

    if (!Rx_EN) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
      perr_d  = 1'b0;
    end else if (Rx_sample_enable) begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          cnt_d  = '0;
          idx_d  = '0;
          perr_d = 1'b0;
          if (!rxd_sync_q) begin
            state_d = StStart;
            cnt_d   = CntW'(1);
          end
        end
        StStart: begin
          // Re-zeroing here puts every later LastTick sample at mid-bit.
          if (cnt_q == MidTick) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rxd_sync_q ? StIdle : StData;
          end
        end
        StData: begin
          if (cnt_q == LastTick) begin
            shift_en = 1'b1;
            idx_d    = idx_q + 1'b1;
            if (idx_q == LastBit) begin
              idx_d   = '0;
              state_d = (PARITY_EN != 0) ? StParity : StStop;
            end
          end
        end
        StParity: begin
          if (cnt_q == LastTick) begin
            perr_d  = rxd_sync_q != calc_parity(32'(sipo_out), PARITY_ODD != 0);
            state_d = StStop;
          end
        end
        StStop: begin
          if (cnt_q == LastTick) begin
            state_d  = StIdle;
            cnt_d    = '0;
            ferror_d = !rxd_sync_q;
            perror_d = perr_q;
            if (rxd_sync_q && !perr_q) begin
              valid_d = 1'b1;
              data_d  = sipo_out;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters, held data and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      perr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perror_q <= 1'b0;
      ferror_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      perr_q   <= perr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perror_q <= perror_d;
      ferror_q <= ferror_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perror_q;
  assign Rx_FERROR = ferror_q;
  assign Rx_BUSY   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a serial driver queues the expected frame
// outcome, a monitor pops and compares whenever the receiver strobes.
module tb_uart_rx_ctrl;

  localparam int unsigned DB = 8;
  localparam int unsigned OS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          RxD;
  logic          Rx_EN;
  logic          Rx_sample_enable;
  logic [DB-1:0] Rx_DATA;
  logic          Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY;

  uart_rx_ctrl #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .RxD             (RxD),
    .Rx_EN           (Rx_EN),
    .Rx_sample_enable(Rx_sample_enable),
    .Rx_DATA         (Rx_DATA),
    .Rx_VALID        (Rx_VALID),
    .Rx_PERROR       (Rx_PERROR),
    .Rx_FERROR       (Rx_FERROR),
    .Rx_BUSY         (Rx_BUSY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    logic          valid;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t          sb_q[$];
  logic [DB-1:0] last_good = '0;
  int            total = 0;
  int            bad = 0;
  int            tick_div = 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference outcome of a frame: even parity over data+parity bit, stop must be high.
  function automatic exp_t model(logic [DB-1:0] data, logic pbit, logic stop);
    exp_t e;
    int   ones = 0;
    for (int i = 0; i < DB; i++) ones += data[i];
    ones += pbit;
    e.data  = data;
    e.perr  = (ones % 2) != 0;
    e.ferr  = !stop;
    e.valid = stop && !e.perr;
    return e;
  endfunction

  // Sample-enable generator: one pulse every tick_div clocks.
  initial begin
    int c;
    c = 0;
    Rx_sample_enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (c >= tick_div - 1) begin
        c = 0;
        Rx_sample_enable = 1'b1;
      end else begin
        c++;
        Rx_sample_enable = 1'b0;
      end
    end
  end

  task automatic wait_ticks(int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (Rx_sample_enable !== 1'b1);
    end
    #2;
  endtask

  task automatic idle_bits(int n);
    RxD = 1'b1;
    wait_ticks(n * OS);
  endtask

  // Drives one frame LSB-first. A low stop bit returns high just after its
  // sample point so the line is not read as a fresh start bit.
  task automatic send_frame(logic [DB-1:0] data, logic pbit, logic stop);
    sb_q.push_back(model(data, pbit, stop));
    RxD = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      RxD = data[i];
      wait_ticks(OS);
    end
    RxD = pbit;
    wait_ticks(OS);
    RxD = stop;
    if (stop) begin
      wait_ticks(OS);
    end else begin
      wait_ticks(OS / 2 + 2);
      RxD = 1'b1;
      wait_ticks(OS / 2 - 2);
    end
    RxD = 1'b1;
  endtask

  // Starts a frame and abandons it halfway through data bit 3.
  task automatic send_abort(logic [DB-1:0] data, bit use_reset);
    RxD = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      RxD = data[i];
      wait_ticks(OS);
    end
    RxD = data[3];
    wait_ticks(OS / 2);
    check("abort_busy_before", Rx_BUSY, 1);
    if (use_reset) begin
      #1 reset = 1'b1;
      #1;
      check("abort_reset_data", Rx_DATA, 0);
      check("abort_reset_busy", Rx_BUSY, 0);
      check("abort_reset_strobes", {Rx_VALID, Rx_PERROR, Rx_FERROR}, 0);
      last_good = '0;
      RxD = 1'b1;
      @(posedge clk);
      #3 reset = 1'b0;
    end else begin
      Rx_EN = 1'b0;
      RxD   = 1'b1;
      @(posedge clk);
      #2;
      check("abort_en_busy", Rx_BUSY, 0);
      check("abort_en_data_held", Rx_DATA, last_good);
      repeat (3) @(posedge clk);
      #2 Rx_EN = 1'b1;
    end
  endtask

  // Monitor: every strobe cycle consumes one expected outcome.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    logic strobe;
    exp_t e;
    strobe = Rx_VALID | Rx_PERROR | Rx_FERROR;
    if (!reset && strobe) begin
      check("strobe_back_to_back", prev_strobe, 0);
      if (sb_q.size() == 0) begin
        check("strobe_unexpected", strobe, 0);
      end else begin
        e = sb_q.pop_front();
        check("valid", Rx_VALID, e.valid);
        check("perror", Rx_PERROR, e.perr);
        check("ferror", Rx_FERROR, e.ferr);
        if (e.valid) last_good = e.data;
        check("rx_data", Rx_DATA, last_good);
      end
    end
    prev_strobe = strobe;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DB-1:0] d;
    logic          pbit, stop;
    int            gap;

    reset = 1'b1;
    Rx_EN = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_data", Rx_DATA, 0);
    check("reset_valid", Rx_VALID, 0);
    check("reset_perror", Rx_PERROR, 0);
    check("reset_ferror", Rx_FERROR, 0);
    check("reset_busy", Rx_BUSY, 0);
    reset = 1'b0;
    idle_bits(2);

    // Good frame, bad parity, bad stop, then recovery.
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(2);
    check("busy_after_good", Rx_BUSY, 0);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_bits(2);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_bits(3);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    check("data_3c", Rx_DATA, 8'h3C);

    // Start glitch: four ticks low, then high.
    RxD = 1'b0;
    wait_ticks(4);
    RxD = 1'b1;
    check("glitch_busy_high", Rx_BUSY, 1);
    wait_ticks(OS);
    check("glitch_busy_low", Rx_BUSY, 0);
    idle_bits(1);

    // Slow ticks, back-to-back frames.
    tick_div = 5;
    idle_bits(1);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle_bits(2);
    check("data_ff", Rx_DATA, 8'hFF);
    tick_div = 1;
    idle_bits(1);

    // Aborted frames followed by a clean one.
    send_abort(8'h5A, 1'b1);
    idle_bits(2);
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(2);
    send_abort(8'hF0, 1'b0);
    idle_bits(2);
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(2);
    check("data_81", Rx_DATA, 8'h81);

    // Randomized frames with occasional parity/stop corruption.
    for (int n = 0; n < 30; n++) begin
      tick_div = $urandom_range(1, 4);
      idle_bits(1);
      d    = DB'($urandom);
      pbit = ^d;
      if ($urandom_range(0, 4) == 0) pbit = ~pbit;
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, pbit, stop);
      gap = stop ? $urandom_range(0, 3) : $urandom_range(2, 4);
      idle_bits(gap);
      if (gap >= 2) check("busy_rand", Rx_BUSY, 0);
    end

    idle_bits(2);
    check("scoreboard_drained", sb_q.size(), 0);
    check("final_data", Rx_DATA, last_good);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
